// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execute controller: opcodes, FSM encoding and
// default sizes.
package alu_exec_ctrl_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 8;

    localparam logic [3:0] OP_NOTA       = 4'd0;
    localparam logic [3:0] OP_NOTB       = 4'd1;
    localparam logic [3:0] OP_AND        = 4'd2;
    localparam logic [3:0] OP_OR         = 4'd3;
    localparam logic [3:0] OP_XOR        = 4'd4;
    localparam logic [3:0] OP_XNOR       = 4'd5;
    localparam logic [3:0] OP_SLT        = 4'd6;
    localparam logic [3:0] OP_SGT        = 4'd7;
    localparam logic [3:0] OP_LSL        = 4'd8;
    localparam logic [3:0] OP_LSR        = 4'd9;
    localparam logic [3:0] OP_ASR        = 4'd10;
    localparam logic [3:0] OP_ADD        = 4'd11;
    localparam logic [3:0] OP_SUB        = 4'd12;
    localparam logic [3:0] OP_LAST_LEGAL = OP_SUB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } exec_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// 8x32 register file: one synchronous write port, two combinational read
// ports, register 0 hardwired to zero. Reset clears every entry.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    output logic [DW-1:0]           rdata_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DW-1:0]           rdata_b
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller in front of the combinational ALU: accepts an
// instruction, reads operands, drives the ALU, captures and writes back.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0]              i_op,
    input  logic [$clog2(NREG)-1:0] i_ra,
    input  logic [$clog2(NREG)-1:0] i_rb,
    input  logic [$clog2(NREG)-1:0] i_rd,
    input  logic                    i_wr_en,
    input  logic [$clog2(NREG)-1:0] i_wr_addr,
    input  logic [DW-1:0]           i_wr_data,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [3:0]              alu_op,
    input  logic [DW-1:0]           alu_result,
    output logic                    o_valid,
    output logic [DW-1:0]           o_result,
    output logic                    o_zero,
    output logic                    o_err,
    output exec_state_t             dbg_state
);

    localparam int AW = $clog2(NREG);

    exec_state_t   state_q, state_d;
    logic [3:0]    op_q;
    logic [AW-1:0] ra_q, rb_q, rd_q;
    logic [DW-1:0] a_q, b_q, result_q;
    logic          zero_q, err_q;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          in_idle, take_legal, take_illegal;

    // Handshake: an instruction transfers on a rising edge where i_valid and
    // o_ready are both high; o_ready is high only in IDLE. Illegal opcodes are
    // consumed without leaving IDLE and answered by a one-cycle o_err.
    assign in_idle      = (state_q == S_IDLE);
    assign take_legal   = in_idle && i_valid && is_legal_op(i_op);
    assign take_illegal = in_idle && i_valid && !is_legal_op(i_op);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take_legal) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= take_illegal;
            if (take_legal) begin
                op_q <= i_op;
                ra_q <= i_ra;
                rb_q <= i_rb;
                rd_q <= i_rd;
            end
            if (state_q == S_READ) begin
                a_q <= rf_rdata_a;
                b_q <= rf_rdata_b;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result;
                zero_q   <= (alu_result == '0);
            end
        end
    end

    // Host loads and writeback never coincide: host writes only land in IDLE.
    assign rf_we    = (in_idle && i_wr_en) || (state_q == S_WB);
    assign rf_waddr = (state_q == S_WB) ? rd_q : i_wr_addr;
    assign rf_wdata = (state_q == S_WB) ? result_q : i_wr_data;

    alu_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ra_q),
        .rdata_a (rf_rdata_a),
        .raddr_b (rb_q),
        .rdata_b (rf_rdata_b)
    );

    assign o_ready   = in_idle;
    assign o_valid   = (state_q == S_WB);
    assign o_result  = result_q;
    assign o_zero    = zero_q;
    assign o_err     = err_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_op = '0;
    logic [2:0]  i_ra = '0, i_rb = '0, i_rd = '0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        o_valid, o_zero, o_err;
    logic [31:0] o_result;
    exec_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_ra       (i_ra),
        .i_rb       (i_rb),
        .i_rd       (i_rd),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_err      (o_err),
        .dbg_state  (dbg_state)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return ~a;
            4'd1:    return ~b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a ^ b);
            4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:    return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return {b[30:0], 1'b0};
            4'd9:    return {1'b0, b[31:1]};
            4'd10:   return {b[31], b[31:1]};
            4'd11:   return a + b;
            4'd12:   return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU sits outside the controller; model it here.
    always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [8];
    int          busy = 0;        // cycles until the controller is free again
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]  m_op = '0;
    logic        m_zero = 1'b0, m_err = 1'b0;
    logic [31:0] p_a, p_b, p_res;
    logic [2:0]  p_rd;
    logic [31:0] exp_q[$];
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            busy = 0; m_a = '0; m_b = '0; m_res = '0; m_op = '0;
            m_zero = 1'b0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            m_err = 1'b0;
            if (busy == 3) begin
                m_a = p_a; m_b = p_b; busy = 2;
            end else if (busy == 2) begin
                m_res = p_res; m_zero = (p_res == 0); busy = 1;
            end else if (busy == 1) begin
                if (p_rd != 0) m_regs[p_rd] = p_res;
                busy = 0;
            end else begin
                if (i_wr_en && i_wr_addr != 0) m_regs[i_wr_addr] = i_wr_data;
                if (i_valid) begin
                    if (i_op > 4'd12) begin
                        m_err = 1'b1;
                    end else begin
                        m_op  = i_op;
                        p_a   = m_regs[i_ra];
                        p_b   = m_regs[i_rb];
                        p_rd  = i_rd;
                        p_res = alu_ref(i_op, p_a, p_b);
                        exp_q.push_back(p_res);
                        busy  = 3;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("o_ready", 32'(o_ready), 32'(busy == 0));
            check("o_valid", 32'(o_valid), 32'(busy == 1));
            check("o_err",   32'(o_err),   32'(m_err));
            check("alu_a",   alu_a,        m_a);
            check("alu_b",   alu_b,        m_b);
            check("alu_op",  32'(alu_op),  32'(m_op));
            check("o_result", o_result,    m_res);
            check("o_zero",  32'(o_zero),  32'(m_zero));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    check("sb_result", o_result, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_load(input logic [2:0] addr, input logic [31:0] data);
        i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd);
        int n = 0;
        i_valid = 1'b1; i_op = op; i_ra = ra; i_rb = rb; i_rd = rd;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        i_wr_en = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, output logic [31:0] res);
        int n = 0;
        issue(op, ra, rb, rd);
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd2);
        res = o_result;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(o_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        int accepts;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_result", o_result, 32'd0);

        // ADD and read-back
        host_load(3'd1, 32'd5);
        host_load(3'd2, 32'd3);
        run_op(4'd11, 3'd1, 3'd2, 3'd3, r);
        check("add_5_3", r, 32'd8);
        check("add_zero", 32'(o_zero), 32'd0);
        tick();
        run_op(4'd11, 3'd3, 3'd0, 3'd5, r);
        check("readback_r3", r, 32'd8);
        tick();

        // SUB to zero, ASR of negative
        host_load(3'd1, 32'd3);
        host_load(3'd2, 32'd3);
        run_op(4'd12, 3'd1, 3'd2, 3'd4, r);
        check("sub_zero", r, 32'd0);
        check("sub_zero_flag", 32'(o_zero), 32'd1);
        tick();
        host_load(3'd2, 32'h8000_0000);
        run_op(4'd10, 3'd0, 3'd2, 3'd5, r);
        check("asr_neg", r, 32'hC000_0000);
        tick();

        // Illegal opcode, next instruction accepted immediately
        issue(4'd13, 3'd1, 3'd2, 3'd6);
        check("err_pulse", 32'(o_err), 32'd1);
        check("err_ready", 32'(o_ready), 32'd1);
        run_op(4'd11, 3'd1, 3'd2, 3'd6, r);
        check("after_err_add", r, 32'h8000_0003);
        tick();

        // i_valid held through busy cycles; host load in EXEC ignored
        host_load(3'd1, 32'd7);
        i_valid = 1'b1; i_op = 4'd11; i_ra = 3'd1; i_rb = 3'd2; i_rd = 3'd6;
        accepts = 0;
        for (int c = 0; c < 9; c++) begin
            if (o_ready) accepts++;
            i_wr_en = (c == 2); i_wr_addr = 3'd1; i_wr_data = 32'd99;
            tick();
        end
        i_valid = 1'b0; i_wr_en = 1'b0;
        check("held_accepts", 32'(accepts), 32'd3);
        wait_ready();
        run_op(4'd11, 3'd1, 3'd0, 3'd7, r);
        check("busy_load_ignored", r, 32'd7);
        tick();

        // rd == ra == rb
        run_op(4'd11, 3'd1, 3'd1, 3'd1, r);
        check("self_add_1", r, 32'd14);
        tick();
        run_op(4'd11, 3'd1, 3'd1, 3'd1, r);
        check("self_add_2", r, 32'd28);
        tick();

        // r0 stays zero for host and writeback
        host_load(3'd0, 32'd55);
        run_op(4'd11, 3'd0, 3'd0, 3'd2, r);
        check("r0_host", r, 32'd0);
        tick();
        run_op(4'd11, 3'd1, 3'd1, 3'd0, r);
        check("wb_r0_result", r, 32'd56);
        tick();
        run_op(4'd11, 3'd0, 3'd0, 3'd3, r);
        check("r0_wb", r, 32'd0);
        tick();

        // Host load and accept in the same IDLE cycle
        i_wr_en = 1'b1; i_wr_addr = 3'd4; i_wr_data = 32'd21;
        run_op(4'd11, 3'd4, 3'd0, 3'd5, r);
        check("same_cycle_load", r, 32'd21);
        tick();

        // Reset during EXEC aborts
        issue(4'd11, 3'd1, 3'd1, 3'd3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_valid", 32'(o_valid), 32'd0);
        repeat (3) tick();
        run_op(4'd11, 3'd1, 3'd2, 3'd3, r);
        check("abort_cleared", r, 32'd0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            i_valid   = 1'($urandom_range(0, 1));
            i_op      = 4'($urandom_range(0, 15));
            i_ra      = 3'($urandom_range(0, 7));
            i_rb      = 3'($urandom_range(0, 7));
            i_rd      = 3'($urandom_range(0, 7));
            i_wr_en   = ($urandom_range(0, 2) == 0);
            i_wr_addr = 3'($urandom_range(0, 7));
            i_wr_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            tick();
        end
        reset = 1'b0; i_valid = 1'b0; i_wr_en = 1'b0;
        repeat (6) tick();
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
